// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and
// the legal operand-width range.
package serial_adder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
// The requester drives the operands and start; the adder returns the status and the result.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, cin, a, b,
                  input  busy, done, s, cout, ovf);
  modport slave  (input  start, sub, cin, a, b,
                  output busy, done, s, cout, ovf);
endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder built from two half adders.
// Used as the single arithmetic slice of serial_adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_s1, w_c1, w_c2;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1), .o_c(w_c1));
  half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s),  .o_c(w_c2));

  assign o_cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// The outputs are updated only on the completion edge, so no partial sums are ever visible.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_adder: WIDTH out of legal range 2..32");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic w_sum;
  logic w_co;
  logic w_last;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B at capture and force the carry-in.
          r_state <= ST_RUN;
          r_a     <= bus.a;
          r_b     <= bus.sub ? ~bus.b : bus.b;
          r_carry <= bus.sub ? 1'b1 : bus.cin;
          r_cnt   <= '0;
        end
      end else begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
        r_carry <= w_co;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          // r_carry still holds the carry into the MSB on this edge.
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_s     <= {w_sum, r_acc[WIDTH-1:1]};
          r_cout  <= w_co;
          r_ovf   <= r_carry ^ w_co;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// It compares the DUT every cycle against a latency-counting arithmetic model, and also checks literal results for the directed cases.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // {ovf, cout, s} from plain arithmetic on the operands.
  function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
    logic [W-1:0] bo;
    logic [W:0]   sum;
    logic         ov;
    bo  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bo} + ((sub || cin) ? 1 : 0);
    ov  = (a[W-1] == bo[W-1]) && (sum[W-1] != a[W-1]);
    return {ov, sum[W], sum[W-1:0]};
  endfunction

  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_s;
  logic [W+1:0] m_pend;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_s <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      m_left <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          m_left <= W;
          m_pend <= model_op(bus.a, bus.b, bus.cin, bus.sub);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_ovf, m_cout, m_s} <= m_pend;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    n_chk++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.s} !== {m_busy, m_done, m_cout, m_ovf, m_s}) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b s=%h cout=%b ovf=%b want busy=%b done=%b s=%h cout=%b ovf=%b",
               $time, bus.busy, bus.done, bus.s, bus.cout, bus.ovf, m_busy, m_done, m_s, m_cout, m_ovf);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
  endtask

  // Waits (bounded) for DONE, counting BUSY cycles; call at the negedge after the accepting edge.
  task automatic wait_done(input string name, output int busy_cnt);
    bit seen;
    seen = 0;
    busy_cnt = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin seen = 1; break; end
      @(negedge clk);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom); bus.cin = 1'($urandom);
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout got=no_done want=done", name);
    end
  endtask

  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic cin, input logic sub,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int bc;
    @(negedge clk);
    drive(a, b, cin, sub);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(name, bc);
    chk({name, "_busycycles"}, bc, W);
    chk({name, "_s"}, bus.s, es);
    chk({name, "_cout"}, bus.cout, ec);
    chk({name, "_ovf"}, bus.ovf, eo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    bus.start = 0; bus.sub = 0; bus.cin = 0; bus.a = '0; bus.b = '0;

    // 1. reset held, START toggling: outputs stay at reset values
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = ~bus.start; bus.a = 8'hAA; bus.b = 8'h55;
      chk("reset_out", {bus.busy, bus.done, bus.cout, bus.ovf, bus.s}, '0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // 2-4. directed arithmetic
    op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op("add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // 5. START while busy is ignored; START in DONE cycle accepted
    @(negedge clk);
    drive(8'h20, 8'h03, 1'b0, 1'b0);
    @(negedge clk);                       // after e0
    bus.start = 1'b0;
    @(negedge clk);                       // after e0+1
    @(negedge clk);                       // after e0+2
    drive(8'hFF, 8'hFF, 1'b1, 1'b1);      // sampled at e0+3
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore", bc);
    chk("ignore_s", bus.s, 8'h23);
    chk("ignore_cout", bus.cout, 1'b0);
    drive(8'h40, 8'h02, 1'b0, 1'b1);      // in the DONE cycle
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1'b1);
    wait_done("b2b", bc);
    chk("b2b_busycycles", bc, W);
    chk("b2b_s", bus.s, 8'h3E);
    chk("b2b_cout", bus.cout, 1'b1);

    // 6. reset mid-run aborts without DONE
    @(negedge clk);
    drive(8'h55, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);            // e0+4
    #1 rst_n = 1'b0;
    #1 chk("abort_busy", bus.busy, 1'b0);
    chk("abort_out", {bus.done, bus.cout, bus.ovf, bus.s}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_nodone", bus.done, 1'b0);
    end
    op("after_rst", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

    // Random traffic: START often asserted while busy, operands churn every cycle.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
